// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven set-time / set-alarm control stage
//
// Turns four raw push-buttons into the mode, edit value and per-field load
// enables used by the hour/minute/second counters, and holds the alarm time.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   btn_mode/next/up/down raw asynchronous active-high buttons
//   cur_hour/min/sec      running time, sampled on entry to SET_TIME
//   state                 00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 FINISH
//   num                   value of the field being edited (hour zero-extended)
//   hour/min/sec_enable   counter load enables
//   alarm_hour/min        stored alarm time
//   alarm_on              set once any alarm field has been edited
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [1:0] state,
  output logic [5:0] num,
  output logic       hour_enable,
  output logic       min_enable,
  output logic       sec_enable,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_on
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_SET_TIME  = 2'b01,
    ST_SET_ALARM = 2'b10,
    ST_FINISH    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    F_SEC  = 2'b00,
    F_MIN  = 2'b01,
    F_HOUR = 2'b10
  } field_t;

  // ---------------------------------------------------------------------
  // Button conditioning: bit 3 mode, bit 2 next, bit 1 up, bit 0 down
  // ---------------------------------------------------------------------
  logic [3:0]       btn_raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       deb;
  logic [3:0]       deb_q;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       pulse;

  assign btn_raw = {btn_mode, btn_next, btn_up, btn_down};

  // The counter only runs while the synchronized level disagrees with the
  // accepted level; any agreeing sample restarts it, so a bounce shorter
  // than DEBOUNCE_CYCLES never gets through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign pulse = deb & ~deb_q;

  // Coincident pulses: only the highest-priority one acts.
  logic mode_p, next_p, up_p, down_p;
  assign mode_p = pulse[3];
  assign next_p = pulse[2] & ~pulse[3];
  assign up_p   = pulse[1] & ~(|pulse[3:2]);
  assign down_p = pulse[0] & ~(|pulse[3:1]);

  // ---------------------------------------------------------------------
  // Modulo helpers
  // ---------------------------------------------------------------------
  function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] step24(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  // ---------------------------------------------------------------------
  // Mode FSM and edit registers
  // ---------------------------------------------------------------------
  state_t     state_q, state_n;
  field_t     field_q, field_n;
  logic [4:0] work_h_q, work_h_n;
  logic [5:0] work_m_q, work_m_n;
  logic [5:0] work_s_q, work_s_n;
  logic       ed_h_q, ed_h_n;
  logic       ed_m_q, ed_m_n;
  logic       ed_s_q, ed_s_n;
  logic [4:0] alarm_hour_n;
  logic [5:0] alarm_min_n;
  logic       alarm_on_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      field_q    <= F_SEC;
      work_h_q   <= '0;
      work_m_q   <= '0;
      work_s_q   <= '0;
      ed_h_q     <= 1'b0;
      ed_m_q     <= 1'b0;
      ed_s_q     <= 1'b0;
      alarm_hour <= '0;
      alarm_min  <= '0;
      alarm_on   <= 1'b0;
    end else begin
      state_q    <= state_n;
      field_q    <= field_n;
      work_h_q   <= work_h_n;
      work_m_q   <= work_m_n;
      work_s_q   <= work_s_n;
      ed_h_q     <= ed_h_n;
      ed_m_q     <= ed_m_n;
      ed_s_q     <= ed_s_n;
      alarm_hour <= alarm_hour_n;
      alarm_min  <= alarm_min_n;
      alarm_on   <= alarm_on_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    field_n      = field_q;
    work_h_n     = work_h_q;
    work_m_n     = work_m_q;
    work_s_n     = work_s_q;
    ed_h_n       = ed_h_q;
    ed_m_n       = ed_m_q;
    ed_s_n       = ed_s_q;
    alarm_hour_n = alarm_hour;
    alarm_min_n  = alarm_min;
    alarm_on_n   = alarm_on;
    num          = '0;
    hour_enable  = 1'b0;
    min_enable   = 1'b0;
    sec_enable   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mode_p) begin
          state_n  = ST_SET_TIME;
          field_n  = F_SEC;
          work_h_n = cur_hour;
          work_m_n = cur_min;
          work_s_n = cur_sec;
          ed_h_n   = 1'b0;
          ed_m_n   = 1'b0;
          ed_s_n   = 1'b0;
        end
      end

      ST_SET_TIME: begin
        // The selected counter is held loaded with the working value so the
        // display tracks the edit live.
        case (field_q)
          F_HOUR: begin
            num         = {1'b0, work_h_q};
            hour_enable = 1'b1;
          end
          F_MIN: begin
            num        = work_m_q;
            min_enable = 1'b1;
          end
          default: begin
            num        = work_s_q;
            sec_enable = 1'b1;
          end
        endcase

        if (mode_p) begin
          state_n = ST_SET_ALARM;
          field_n = F_MIN;
        end else if (next_p) begin
          case (field_q)
            F_SEC:   field_n = F_MIN;
            F_MIN:   field_n = F_HOUR;
            default: field_n = F_SEC;
          endcase
        end else if (up_p || down_p) begin
          case (field_q)
            F_HOUR: begin
              work_h_n = step24(work_h_q, up_p);
              ed_h_n   = 1'b1;
            end
            F_MIN: begin
              work_m_n = step60(work_m_q, up_p);
              ed_m_n   = 1'b1;
            end
            default: begin
              work_s_n = step60(work_s_q, up_p);
              ed_s_n   = 1'b1;
            end
          endcase
        end
      end

      ST_SET_ALARM: begin
        num = (field_q == F_HOUR) ? {1'b0, alarm_hour} : alarm_min;

        if (mode_p) begin
          state_n = ST_FINISH;
        end else if (next_p) begin
          field_n = (field_q == F_HOUR) ? F_MIN : F_HOUR;
        end else if (up_p || down_p) begin
          if (field_q == F_HOUR) alarm_hour_n = step24(alarm_hour, up_p);
          else                   alarm_min_n  = step60(alarm_min, up_p);
          alarm_on_n = 1'b1;
        end
      end

      default: begin
        // FINISH: one-cycle commit of only the fields that were edited.
        hour_enable = ed_h_q;
        min_enable  = ed_m_q;
        sec_enable  = ed_s_q;
        state_n     = ST_RUN;
        ed_h_n      = 1'b0;
        ed_m_n      = 1'b0;
        ed_s_n      = 1'b0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_next, btn_up, btn_down;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic [1:0] state;
  logic [5:0] num;
  logic       hour_enable, min_enable, sec_enable;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_on;

  always #5 clk = ~clk;

  time_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .state(state), .num(num),
    .hour_enable(hour_enable), .min_enable(min_enable), .sec_enable(sec_enable),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_on(alarm_on)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int en_now();
    return {29'd0, hour_enable, min_enable, sec_enable};
  endfunction

  // Reference model: fields indexed 0 sec, 1 min, 2 hour.
  int m_st, m_f, m_ah, m_am, m_aon, m_fin;
  int m_w[3];
  int m_ed[3];
  int md[3] = '{60, 60, 24};

  task automatic model_reset();
    m_st = 0; m_f = 0; m_ah = 0; m_am = 0; m_aon = 0; m_fin = -1;
    for (int i = 0; i < 3; i++) begin m_w[i] = 0; m_ed[i] = 0; end
  endtask

  task automatic model_apply(input logic [3:0] b);
    int d;
    m_fin = -1;
    d = b[1] ? 1 : -1;
    if (b[3]) begin
      if (m_st == 0) begin
        m_st = 1; m_f = 0;
        m_w[0] = int'(cur_sec); m_w[1] = int'(cur_min); m_w[2] = int'(cur_hour);
        for (int i = 0; i < 3; i++) m_ed[i] = 0;
      end else if (m_st == 1) begin
        m_st = 2; m_f = 1;
      end else begin
        m_fin = m_ed[2] * 4 + m_ed[1] * 2 + m_ed[0];
        m_st = 0;
        for (int i = 0; i < 3; i++) m_ed[i] = 0;
      end
    end else if (b[2]) begin
      if (m_st == 1) m_f = (m_f + 1) % 3;
      else if (m_st == 2) m_f = (m_f == 1) ? 2 : 1;
    end else if (b[1] || b[0]) begin
      if (m_st == 1) begin
        m_w[m_f] = (m_w[m_f] + md[m_f] + d) % md[m_f];
        m_ed[m_f] = 1;
      end else if (m_st == 2) begin
        if (m_f == 2) m_ah = (m_ah + 24 + d) % 24;
        else          m_am = (m_am + 60 + d) % 60;
        m_aon = 1;
      end
    end
  endtask

  function automatic int model_num();
    if (m_st == 1) return m_w[m_f];
    if (m_st == 2) return (m_f == 2) ? m_ah : m_am;
    return 0;
  endfunction

  function automatic int model_en();
    return (m_st == 1) ? (1 << m_f) : 0;
  endfunction

  // Holds a button mask, releases it, and watches every cycle of the window.
  task automatic press(input logic [3:0] b, input int hold,
                       output int changes, output int fin_cnt, output int fin_en);
    logic [1:0] prev;
    changes = 0; fin_cnt = 0; fin_en = -1;
    prev = state;
    {btn_mode, btn_next, btn_up, btn_down} = b;
    for (int i = 0; i < hold + 14; i++) begin
      if (i == hold) {btn_mode, btn_next, btn_up, btn_down} = 4'b0000;
      @(negedge clk);
      if (state != prev) changes++;
      prev = state;
      if (state == 2'b11) begin
        fin_cnt++;
        fin_en = en_now();
      end
    end
  endtask

  typedef struct {
    logic [3:0] btn;
    int hold;
    int ch, cm, cs;
    int st, nm, en, ah, am, aon, fin;
  } vec_t;

  vec_t tv[22];

  initial begin
    int ch_n, fc, fe, prev_st, exp_ch;
    logic [3:0] b;

    // Fields: btn{mode,next,up,down}, hold, cur h/m/s, state, num, en{h,m,s}, alarm h/m/on, finish en
    tv[0]  = '{4'b1000,  3, 0, 10, 37, 0,  0, 0,  0, 0, 0, -1};
    tv[1]  = '{4'b1000, 10, 0, 10, 37, 1, 37, 1,  0, 0, 0, -1};
    tv[2]  = '{4'b0100, 10, 0, 10, 37, 1, 10, 2,  0, 0, 0, -1};
    tv[3]  = '{4'b0010, 10, 0, 10, 37, 1, 11, 2,  0, 0, 0, -1};
    tv[4]  = '{4'b0010, 10, 0, 10, 37, 1, 12, 2,  0, 0, 0, -1};
    tv[5]  = '{4'b1010, 10, 0, 10, 37, 2,  0, 0,  0, 0, 0, -1};
    tv[6]  = '{4'b1000, 10, 0, 10, 37, 0,  0, 0,  0, 0, 0,  2};
    tv[7]  = '{4'b1000, 10, 0, 10, 59, 1, 59, 1,  0, 0, 0, -1};
    tv[8]  = '{4'b0010, 10, 0, 10, 59, 1,  0, 1,  0, 0, 0, -1};
    tv[9]  = '{4'b0001, 10, 0, 10, 59, 1, 59, 1,  0, 0, 0, -1};
    tv[10] = '{4'b0100, 10, 0, 10, 59, 1, 10, 2,  0, 0, 0, -1};
    tv[11] = '{4'b0100, 10, 0, 10, 59, 1,  0, 4,  0, 0, 0, -1};
    tv[12] = '{4'b0001, 10, 0, 10, 59, 1, 23, 4,  0, 0, 0, -1};
    tv[13] = '{4'b0101, 10, 0, 10, 59, 1, 59, 1,  0, 0, 0, -1};
    tv[14] = '{4'b1000, 10, 0, 10, 59, 2,  0, 0,  0, 0, 0, -1};
    tv[15] = '{4'b0010, 10, 0, 10, 59, 2,  1, 0,  0, 1, 1, -1};
    tv[16] = '{4'b0010, 10, 0, 10, 59, 2,  2, 0,  0, 2, 1, -1};
    tv[17] = '{4'b0010, 10, 0, 10, 59, 2,  3, 0,  0, 3, 1, -1};
    tv[18] = '{4'b0100, 10, 0, 10, 59, 2,  0, 0,  0, 3, 1, -1};
    tv[19] = '{4'b0001, 10, 0, 10, 59, 2, 23, 0, 23, 3, 1, -1};
    tv[20] = '{4'b1000, 10, 0, 10, 59, 0,  0, 0, 23, 3, 1,  5};
    tv[21] = '{4'b0010, 10, 0, 10, 59, 0,  0, 0, 23, 3, 1, -1};

    rst = 1'b1;
    {btn_mode, btn_next, btn_up, btn_down} = 4'b0000;
    cur_hour = '0; cur_min = '0; cur_sec = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_num", int'(num), 0);
    chk("reset_en", en_now(), 0);
    chk("reset_alarm_on", int'(alarm_on), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed table
    for (int i = 0; i < 22; i++) begin
      cur_hour = 5'(tv[i].ch); cur_min = 6'(tv[i].cm); cur_sec = 6'(tv[i].cs);
      prev_st = int'(state);
      press(tv[i].btn, tv[i].hold, ch_n, fc, fe);
      exp_ch = (tv[i].fin >= 0) ? 2 : ((tv[i].st != prev_st) ? 1 : 0);
      chk($sformatf("v%0d_changes", i), ch_n, exp_ch);
      chk($sformatf("v%0d_state", i), int'(state), tv[i].st);
      chk($sformatf("v%0d_num", i), int'(num), tv[i].nm);
      chk($sformatf("v%0d_en", i), en_now(), tv[i].en);
      chk($sformatf("v%0d_alarm_hour", i), int'(alarm_hour), tv[i].ah);
      chk($sformatf("v%0d_alarm_min", i), int'(alarm_min), tv[i].am);
      chk($sformatf("v%0d_alarm_on", i), int'(alarm_on), tv[i].aon);
      chk($sformatf("v%0d_finish_cycles", i), fc, (tv[i].fin >= 0) ? 1 : 0);
      if (tv[i].fin >= 0) chk($sformatf("v%0d_finish_en", i), fe, tv[i].fin);
    end

    // Reset in the middle of an edit discards everything
    cur_hour = 5'd7; cur_min = 6'd20; cur_sec = 6'd30;
    press(4'b1000, 10, ch_n, fc, fe);
    press(4'b0010, 10, ch_n, fc, fe);
    chk("pre_reset_num", int'(num), 31);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midreset_state", int'(state), 0);
    chk("midreset_en", en_now(), 0);
    chk("midreset_num", int'(num), 0);
    chk("midreset_alarm_on", int'(alarm_on), 0);
    chk("midreset_alarm_hour", int'(alarm_hour), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_state", int'(state), 0);

    // Randomized presses against the reference model
    model_reset();
    for (int i = 0; i < 80; i++) begin
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) b[3] = 1'b0;
      cur_hour = 5'($urandom_range(0, 23));
      cur_min  = 6'($urandom_range(0, 59));
      cur_sec  = 6'($urandom_range(0, 59));
      press(b, 10, ch_n, fc, fe);
      if (b != 4'b0000) model_apply(b);
      else m_fin = -1;
      chk($sformatf("r%0d_state", i), int'(state), m_st);
      chk($sformatf("r%0d_num", i), int'(num), model_num());
      chk($sformatf("r%0d_en", i), en_now(), model_en());
      chk($sformatf("r%0d_alarm_hour", i), int'(alarm_hour), m_ah);
      chk($sformatf("r%0d_alarm_min", i), int'(alarm_min), m_am);
      chk($sformatf("r%0d_alarm_on", i), int'(alarm_on), m_aon);
      chk($sformatf("r%0d_finish_cycles", i), fc, (m_fin >= 0) ? 1 : 0);
      if (m_fin >= 0) chk($sformatf("r%0d_finish_en", i), fe, m_fin);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected completion before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Upstream control stage of the clock chip: converts four raw push-buttons into the `state[1:0]`, `num[5:0]` and per-field enable signals consumed by the hour/minute/second counters.
- Owns the set-time sequence and the alarm registers.
- Debounces the buttons, runs the mode FSM and edits working values with modulo wrap.
- In FINISH, pulses commit enables so the counters load the edited values.

Parameters:
DEBOUNCE_CYCLES, 1000000, clk cycles a synchronized button level must stay stable before it is accepted (sim uses 4)
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_mode  in  1  raw button, asynchronous to clk, active-high
btn_next  in  1  raw button, selects next field
btn_up  in  1  raw button, increment
btn_down  in  1  raw button, decrement
cur_hour  in  5  running hour from counters, 0..23
cur_min  in  6  running minute, 0..59
cur_sec  in  6  running second, 0..59
state  out  2  00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 FINISH
num  out  6  value of the field being edited (hour zero-extended)
hour_enable  out  1  hour counter load/commit enable
min_enable  out  1  minute counter enable
sec_enable  out  1  second counter enable
alarm_hour  out  5  stored alarm hour
alarm_min  out  6  stored alarm minute
alarm_on  out  1  set once any alarm field is edited

Behaviour:
Reset:
- Async reset clears all outputs, working registers and edited flags to 0; `state` = RUN.
- Reset mid-edit discards all edits.

Buttons:
- Each button passes through a 2-FF synchronizer, then a debounce counter.
- The accepted level updates after DEBOUNCE_CYCLES consecutive equal samples.
- A rising edge of the accepted level gives a 1-clk pulse.
- Press-to-pulse latency is 2 + DEBOUNCE_CYCLES clks (±1). Outputs update on the edge after the pulse.
- Priority when pulses coincide: mode > next > up > down. Lower-priority pulses in that cycle are dropped.

FSM:
- RUN (00):
  - All enables 0; `num` = 0; next/up/down ignored.
  - mode -> SET_TIME. On entry: `field` = SEC; work_h/m/s copy cur_hour/min/sec; edited flags cleared.
- SET_TIME (01):
  - `num` = working value of `field`.
  - Only the enable matching `field` is 1, so the counter captures `num` every cycle.
  - next rotates SEC -> MIN -> HOUR -> SEC.
  - up/down modify the working value and set that field's edited flag.
  - mode -> SET_ALARM with `field` = MIN; all enables 0 in SET_ALARM.
- SET_ALARM (10):
  - `field` limited to MIN/HOUR; next toggles between them.
  - up/down modify `alarm_min`/`alarm_hour` directly and set `alarm_on`.
  - `num` shows the alarm field.
  - mode -> FINISH.
- FINISH (11):
  - Lasts exactly 1 clk.
  - hour/min/sec_enable = respective edited flag, so only edited counters commit; unedited fields keep running time.
  - Then -> RUN; edited flags cleared; enables return to 0.

Arithmetic:
- Minutes/seconds are mod 60: up at 59 -> 0, down at 0 -> 59.
- Hours are mod 24: up at 23 -> 0, down at 0 -> 23.
- `num[5]` = 0 when showing an hour.
- Working values never leave their legal range. `cur_*` inputs are sampled only on RUN -> SET_TIME.

Test Plan:
- Reset mid-SET_TIME with edits pending -> next cycle `state` = 00, all enables 0, `num` = 0, `alarm_on` = 0, `alarm_hour` = 0.
- DEBOUNCE_CYCLES = 4; btn_mode held 3 clks then released (bounce) -> no transition. Held 10 clks -> `state` 00 -> 01 exactly once, `num` = cur_sec (e.g. 37), `sec_enable` = 1.
- SET_TIME, `field` SEC at 59, press up -> `num` = 0. Press down -> `num` = 59. next twice to HOUR with cur_hour = 0, press down -> `num` = 23, `hour_enable` = 1, `sec_enable` = 0.
- Edit only minutes (cur_min 10 -> 12), mode, mode -> FINISH for 1 clk with `min_enable` = 1, `hour_enable` = 0, `sec_enable` = 0 -> then `state` = 00.
- SET_ALARM: `field` MIN, up x3 -> `alarm_min` = 3, `alarm_on` = 1. next, down -> `alarm_hour` = 23. Enables stay 0 throughout; values persist after return to RUN.
- btn_mode and btn_up pulses in same cycle in SET_TIME -> `state` = 10, working value unchanged. btn_next and btn_down coincide -> only the field changes.
